iir_multichannel: RTL

Time-multiplexed, multi-channel direct-form-I IIR filter with per-channel decimation and a folded multiplier array. It is the next-generation replacement for the single-stream IIR in the filter datapath. It serves CHANNELS independent sample streams through one shared multiply-accumulate datapath, keeping separate input and output histories per channel. Coefficients are signed fixed-point and shared by all channels.

---
 rtl/iir_multichannel.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/iir_multichannel.sv
// iir_multichannel: time-multiplexed direct-form-I IIR filter serving CHANNELS
// independent streams through one folded multiply-accumulate datapath.
// Each channel keeps its own x/y histories and decimation counter; the
// coefficients are shared by all channels.
// Optional build macro IIR_SATURATE_EN: clamp the shifted accumulator to the
// DATA_WIDTH signed range instead of keeping its low bits (two's-complement wrap).
module iir_multichannel #(
    parameter int CHANNELS          = 4,
    parameter int TAP_COUNT         = 8,
    parameter int FB_TAP_COUNT      = 3,
    parameter int DECIMATION_FACTOR = 1,
    parameter int MULT_PER_CYCLE    = 2,
    parameter int DATA_WIDTH        = 32,
    parameter int FRAC_BITS         = 0,
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic signed [DATA_WIDTH-1:0]          newData,
    input  logic [CH_W-1:0]                       newDataChannel,
    input  logic                                  newDataAvailable,
    output logic                                  ready,
    input  logic [TAP_COUNT-1:0][DATA_WIDTH-1:0]    FEEDFORWARD_TAPS,
    input  logic [FB_TAP_COUNT-1:0][DATA_WIDTH-1:0] FEEDBACK_TAPS,
    output logic signed [DATA_WIDTH-1:0]          filteredData,
    output logic [CH_W-1:0]                       filteredChannel,
    output logic                                  done
);
    localparam int N_TERMS = TAP_COUNT + FB_TAP_COUNT;
    localparam int P       = (N_TERMS + MULT_PER_CYCLE - 1) / MULT_PER_CYCLE;
    localparam int ACC_W   = 2 * DATA_WIDTH + $clog2(N_TERMS) + 1;
    localparam int CYC_W   = (P > 1) ? $clog2(P) : 1;
    localparam int DEC_W   = (DECIMATION_FACTOR > 1) ? $clog2(DECIMATION_FACTOR) : 1;
    localparam int TI_W    = (TAP_COUNT > 1) ? $clog2(TAP_COUNT) : 1;
    localparam int FI_W    = (FB_TAP_COUNT > 1) ? $clog2(FB_TAP_COUNT) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_OUT   = 2'd2;

    typedef logic signed [DATA_WIDTH-1:0] sample_t;
    typedef logic signed [ACC_W-1:0]      acc_t;

    logic [1:0]       state_q, state_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    acc_t             acc_q, acc_d;
    sample_t          x_q [CHANNELS][TAP_COUNT];
    sample_t          x_d [CHANNELS][TAP_COUNT];
    sample_t          y_q [CHANNELS][FB_TAP_COUNT];
    sample_t          y_d [CHANNELS][FB_TAP_COUNT];
    logic [DEC_W-1:0] dec_q [CHANNELS];
    logic [DEC_W-1:0] dec_d [CHANNELS];
    logic             done_q, done_d;
    sample_t          fdata_q, fdata_d;
    logic [CH_W-1:0]  fchan_q, fchan_d;

    acc_t    group_sum;
    sample_t result;
    logic    chan_ok;

`ifdef IIR_SATURATE_EN
    localparam acc_t SAT_MAX = {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam acc_t SAT_MIN = {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    function automatic sample_t saturate(input acc_t v);
        if (v > SAT_MAX) return SAT_MAX[DATA_WIDTH-1:0];
        if (v < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
        return v[DATA_WIDTH-1:0];
    endfunction
`endif

    // Product term t of the flattened sequence: feedforward terms first, then
    // the (negated) feedback terms; anything past the last term is zero.
    function automatic acc_t term_at(input int t);
        acc_t coef;
        acc_t samp;
        coef = '0;
        samp = '0;
        if (t < TAP_COUNT) begin
            coef = acc_t'(sample_t'(FEEDFORWARD_TAPS[TI_W'(t)]));
            samp = acc_t'(x_q[ch_q][TI_W'(t)]);
        end else if (t < N_TERMS) begin
            coef = -acc_t'(sample_t'(FEEDBACK_TAPS[FI_W'(t - TAP_COUNT)]));
            samp = acc_t'(y_q[ch_q][FI_W'(t - TAP_COUNT)]);
        end
        return coef * samp;
    endfunction

    assign chan_ok = (int'(newDataChannel) < CHANNELS);

    // Sum of the MULT_PER_CYCLE products handled in the current ACCUM cycle.
    always_comb begin
        group_sum = '0;
        for (int m = 0; m < MULT_PER_CYCLE; m++) begin
            group_sum = group_sum + term_at(int'(cyc_q) * MULT_PER_CYCLE + m);
        end
    end

    // Scale the finished accumulator down to an output sample.
    always_comb begin
`ifdef IIR_SATURATE_EN
        result = saturate(acc_q >>> FRAC_BITS);
`else
        result = acc_q[FRAC_BITS +: DATA_WIDTH];
`endif
    end

    // FSM and history next-state: accept/decimate in IDLE, fold the MACs in
    // ACCUM, publish the result and extend the y history in OUT.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        ch_d    = ch_q;
        acc_d   = acc_q;
        x_d     = x_q;
        y_d     = y_q;
        dec_d   = dec_q;
        done_d  = 1'b0;
        fdata_d = fdata_q;
        fchan_d = fchan_q;
        case (state_q)
            S_IDLE: begin
                if (newDataAvailable && chan_ok) begin
                    for (int k = TAP_COUNT - 1; k > 0; k--) begin
                        x_d[newDataChannel][k] = x_q[newDataChannel][k-1];
                    end
                    x_d[newDataChannel][0] = newData;
                    if (dec_q[newDataChannel] != DEC_W'(DECIMATION_FACTOR - 1)) begin
                        dec_d[newDataChannel] = dec_q[newDataChannel] + DEC_W'(1);
                    end else begin
                        dec_d[newDataChannel] = '0;
                        ch_d    = newDataChannel;
                        acc_d   = '0;
                        cyc_d   = '0;
                        state_d = S_ACCUM;
                    end
                end
            end
            S_ACCUM: begin
                acc_d = acc_q + group_sum;
                cyc_d = cyc_q + CYC_W'(1);
                if (cyc_q == CYC_W'(P - 1)) state_d = S_OUT;
            end
            S_OUT: begin
                fdata_d = result;
                fchan_d = ch_q;
                done_d  = 1'b1;
                for (int j = FB_TAP_COUNT - 1; j > 0; j--) begin
                    y_d[ch_q][j] = y_q[ch_q][j-1];
                end
                y_d[ch_q][0] = result;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset discards any in-flight computation.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cyc_q   <= '0;
            ch_q    <= '0;
            acc_q   <= '0;
            x_q     <= '{default: '0};
            y_q     <= '{default: '0};
            dec_q   <= '{default: '0};
            done_q  <= 1'b0;
            fdata_q <= '0;
            fchan_q <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            ch_q    <= ch_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dec_q   <= dec_d;
            done_q  <= done_d;
            fdata_q <= fdata_d;
            fchan_q <= fchan_d;
        end
    end

    assign ready           = (state_q == S_IDLE);
    assign done            = done_q;
    assign filteredData    = fdata_q;
    assign filteredChannel = fchan_q;

endmodule
